// File: rtl/matbi_stream_packer.sv
// matbi_stream_packer: packs RATIO narrow valid/ready beats into one wide word; packet tails are zero-padded.
// Latency: the output word is valid one cycle after its completing input beat is accepted.
// Backpressure: s_ready drops while the output register is full and m_ready is low (combinational from m_ready).
// Optional: define MATBI_STREAM_PACKER_KEEP_EN to add the m_keep lane-valid port.
module matbi_stream_packer #(
  parameter  int IN_WIDTH  = 8,
  parameter  int RATIO     = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int CNT_W     = $clog2(RATIO + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic [CNT_W-1:0]     m_count
`ifdef MATBI_STREAM_PACKER_KEEP_EN
  ,
  output logic [RATIO-1:0]     m_keep
`endif
);

  // RATIO=1 has no accumulator lanes and a single lane index; keep both at a legal width.
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int ACC_W  = (RATIO > 1) ? (RATIO - 1) * IN_WIDTH : IN_WIDTH;

  logic [LANE_W-1:0]    lane_reg;
  logic [ACC_W-1:0]     acc_reg;
  logic [OUT_WIDTH-1:0] word_nxt;
  logic                 accept;
  logic                 completes;

  // Ready only when the output register can take a word this cycle; never during reset.
  assign s_ready   = ~rst && (~m_valid || m_ready);
  assign accept    = s_valid && s_ready;
  assign completes = (lane_reg == LANE_W'(RATIO - 1)) || s_last;

  // Assemble the completing word: stored lanes below lane_reg, the live beat at lane_reg, zeros above.
  always_comb begin
    word_nxt = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (LANE_W'(i) < lane_reg) begin
        word_nxt[i*IN_WIDTH +: IN_WIDTH] = acc_reg[i*IN_WIDTH +: IN_WIDTH];
      end
    end
    for (int i = 0; i < RATIO; i++) begin
      if (LANE_W'(i) == lane_reg) begin
        word_nxt[i*IN_WIDTH +: IN_WIDTH] = s_data;
      end
    end
  end

  // Lane counter and accumulator: store non-completing beats, restart at lane 0 after a completing one.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_reg <= '0;
      acc_reg  <= '0;
    end else if (accept) begin
      if (completes) begin
        lane_reg <= '0;
      end else begin
        lane_reg <= lane_reg + LANE_W'(1);
        for (int i = 0; i < RATIO - 1; i++) begin
          if (lane_reg == LANE_W'(i)) begin
            acc_reg[i*IN_WIDTH +: IN_WIDTH] <= s_data;
          end
        end
      end
    end
  end

  // Output register: reload on a completing beat (even while draining), otherwise clear valid on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_count <= '0;
    end else if (accept && completes) begin
      m_valid <= 1'b1;
      m_data  <= word_nxt;
      m_last  <= s_last;
      m_count <= CNT_W'(lane_reg) + CNT_W'(1);
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef MATBI_STREAM_PACKER_KEEP_EN
  logic [RATIO-1:0] keep_nxt;

  // Thermometer code of the lanes filled up to and including the completing lane.
  always_comb begin
    keep_nxt = '0;
    for (int i = 0; i < RATIO; i++) begin
      keep_nxt[i] = (LANE_W'(i) <= lane_reg);
    end
  end

  // Lane-valid mask loads and holds together with m_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_keep <= '0;
    end else if (accept && completes) begin
      m_keep <= keep_nxt;
    end
  end
`endif

endmodule

// File: doc/matbi_stream_packer.md
Name: matbi_stream_packer

Overview:
- Valid/ready stream width upsizer. Packs RATIO narrow input beats into one wide output word.
- Sits directly upstream of the timing-closure skid buffer and drives its s_valid/s_ready/s_data.
- Output side is fully registered. Honours a packet boundary (s_last), so a short packet tail is emitted as a zero-padded partial word.

Parameters:
- IN_WIDTH, 8: width of one input beat in bits.
- RATIO, 4: number of input beats per output word. Legal range 1..16; RATIO=1 degenerates to a single register stage.
- OUT_WIDTH, IN_WIDTH*RATIO: derived output width. Local, not overridable.
- CNT_W, clog2(RATIO+1): derived width of m_count. Local.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  IN_WIDTH  input beat.
- s_last  in  1  last beat of packet. Sampled only on handshake.
- m_valid  out  1  output word valid (registered).
- m_ready  in  1  downstream ready.
- m_data  out  OUT_WIDTH  packed word (registered).
- m_last  out  1  word closes a packet (registered).
- m_count  out  CNT_W  number of valid lanes in m_data, 1..RATIO (registered).

Behaviour:
- Lane order is little-endian. The first accepted beat of a word goes to bits [IN_WIDTH-1:0]; beat k goes to lane k.
- Internal state:
  - accumulator acc_reg, (RATIO-1)*IN_WIDTH bits;
  - lane counter lane_reg, 0..RATIO-1;
  - output register (m_data/m_valid/m_last/m_count).
- Lane-counter FSM:
  - Each accepted beat that completes no word writes lane lane_reg of acc_reg and increments lane_reg.
  - A beat completes a word when lane_reg==RATIO-1 or s_last==1.
  - On a completing beat, {s_data, acc_reg lanes below lane_reg} loads the output register, and lane_reg returns to 0.
  - m_count loads lane_reg+1 and m_last loads s_last.
- Padding: lanes above the completing lane are 0 in m_data. acc_reg contents from a previous word never leak into it.
- s_ready = ~rst && (~m_valid || m_ready). This is combinational from m_ready. Acceptable because the downstream skid buffer registers its ready.
- s_ready is also deasserted while the output is full and stalled. This holds even for non-completing beats, so ordering stays trivial.
- Handshake rules:
  - m_valid/m_data/m_last/m_count hold stable while m_valid && !m_ready.
  - m_valid clears on an m_valid && m_ready cycle unless a completing beat is accepted in the same cycle.
- Simultaneous output drain and completing input beat: the output register reloads with the new word and m_valid stays 1. Full throughput is 1 output word per RATIO input cycles.
- Latency: the output word is valid one cycle after its completing input beat is accepted.
- s_last on lane 0 produces m_count=1 and a word containing only lane 0.
- Back-to-back packets: the beat after an s_last beat starts at lane 0.
- Reset values: m_valid=0, m_data=0, m_last=0, m_count=0, lane_reg=0, acc_reg=0. s_ready=0 while rst=1.
- Reset mid-packet discards the partial word and any pending output word. No flush is emitted.
- s_data/s_last are don't-care when s_valid=0. No state changes without a handshake.

Optional Feature:
- Macro: MATBI_STREAM_PACKER_KEEP_EN.
- Defined: adds output port m_keep (RATIO bits, registered, reset 0). Bit i=1 if lane i holds valid data, i.e. a thermometer code of m_count (e.g. m_count=3 -> m_keep=4'b0111). It loads and holds with m_data under the same rules.
- Undefined: m_keep port and its logic are absent. m_count remains the only lane indicator.

Test Plan:
- Reset release, then beats 0x11,0x22,0x33,0x44 with s_last=0 and m_ready=1 -> one word 0x44332211 one cycle after the 4th beat, with m_count=4, m_last=0, and s_ready=1 throughout.
- Packet 0xA1,0xA2 with s_last on beat 2 -> m_data=0x0000A2A1, m_count=2, m_last=1 (m_keep=4'b0011 if KEEP_EN). The next beat 0xB1 lands in lane 0.
- Continuous 12-beat stream with m_ready=1 -> 3 words on cycles 5, 9 and 13 after first accept, with no input stall.
- Word pending with m_ready=0 for 5 cycles -> m_* stable and s_ready=0. When m_ready rises in the same cycle as a completing beat, m_valid stays 1 and the new word appears next cycle.
- Single-beat packet 0x5A with s_last=1 -> m_data=0x0000005A, m_count=1, m_last=1.
- Assert rst after 2 beats of a word, then send 0x01..0x04 -> output 0x04030201 with m_count=4; no trace of the pre-reset beats and no spurious m_valid during or after reset.
